// File: rtl/hpdcache_plru_ctrl.sv
// Arbiter/sequencer in front of the HPDcache pseudo-LRU block: buffers hit updates in a
// small FIFO, serializes them with victim requests and returns the victim way registered.
module hpdcache_plru_ctrl #(
  parameter int unsigned SETS            = 64,
  parameter int unsigned WAYS            = 8,
  parameter int unsigned UPDT_FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    updt_valid_i,
  output logic                    updt_ready_o,
  input  logic [$clog2(SETS)-1:0] updt_set_i,
  input  logic [WAYS-1:0]         updt_way_i,

  input  logic                    repl_valid_i,
  output logic                    repl_ready_o,
  input  logic [$clog2(SETS)-1:0] repl_set_i,
  input  logic [WAYS-1:0]         repl_dir_valid_i,
  input  logic                    repl_updt_plru_i,

  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [WAYS-1:0]         rsp_victim_way_o,

  output logic                    plru_updt_o,
  output logic [$clog2(SETS)-1:0] plru_updt_set_o,
  output logic [WAYS-1:0]         plru_updt_way_o,
  output logic                    plru_repl_o,
  output logic [$clog2(SETS)-1:0] plru_repl_set_o,
  output logic [WAYS-1:0]         plru_repl_dir_valid_o,
  output logic                    plru_repl_updt_plru_o,
  input  logic [WAYS-1:0]         plru_victim_way_i,

  output logic                    busy_o
);

  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned PTR_W = $clog2(UPDT_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_t;

  state_t                     r_state;
  logic [WAYS-1:0]            r_rsp_way;
  logic [SET_W-1:0]           r_fifo_set [UPDT_FIFO_DEPTH];
  logic [WAYS-1:0]            r_fifo_way [UPDT_FIFO_DEPTH];
  logic [UPDT_FIFO_DEPTH-1:0] r_fifo_vld;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;

  logic                       w_empty;
  logic                       w_full;
  logic                       w_conflict;
  logic                       w_repl_issue;
  logic                       w_updt_acc;
  logic                       w_bypass;
  logic                       w_enq;
  logic                       w_deq;
  logic [UPDT_FIFO_DEPTH-1:0] w_fifo_vld_nxt;

  assign w_empty = (r_count == CNT_W'(0));
  assign w_full  = (r_count == CNT_W'(UPDT_FIFO_DEPTH));

  // Any occupied entry targeting the requested set must reach the PLRU before the victim pick.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < int'(UPDT_FIFO_DEPTH); i++) begin
      if (r_fifo_vld[i] && (r_fifo_set[i] == repl_set_i)) begin
        w_conflict = 1'b1;
      end
    end
  end

  // Reset gates every PLRU command so stale buffered state never reaches the PLRU.
  assign w_repl_issue = !rst_i && (r_state == ST_IDLE) && repl_valid_i && !w_conflict;
  assign w_updt_acc   = !rst_i && updt_valid_i && !w_full;
  assign w_bypass     = w_updt_acc && w_empty && !w_repl_issue;
  assign w_enq        = w_updt_acc && !w_bypass;
  assign w_deq        = !rst_i && !w_empty && !w_repl_issue;

  always_comb begin
    w_fifo_vld_nxt = r_fifo_vld;
    if (w_deq) w_fifo_vld_nxt[r_rd_ptr] = 1'b0;
    if (w_enq) w_fifo_vld_nxt[r_wr_ptr] = 1'b1;
  end

  // Control state: FSM, pointers, occupancy and response register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_rsp_way  <= '0;
      r_fifo_vld <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_repl_issue) begin
            r_rsp_way <= plru_victim_way_i;
            r_state   <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      r_fifo_vld <= w_fifo_vld_nxt;
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CNT_W'(1);
      else if (!w_enq && w_deq) r_count <= r_count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; validity is tracked by r_fifo_vld.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_fifo_set[r_wr_ptr] <= updt_set_i;
      r_fifo_way[r_wr_ptr] <= updt_way_i;
    end
  end

  assign updt_ready_o          = !w_full;
  assign repl_ready_o          = w_repl_issue;

  assign plru_repl_o           = w_repl_issue;
  assign plru_repl_set_o       = repl_set_i;
  assign plru_repl_dir_valid_o = repl_dir_valid_i;
  assign plru_repl_updt_plru_o = repl_updt_plru_i;

  assign plru_updt_o           = w_bypass || w_deq;
  assign plru_updt_set_o       = w_deq ? r_fifo_set[r_rd_ptr] : updt_set_i;
  assign plru_updt_way_o       = w_deq ? r_fifo_way[r_rd_ptr] : updt_way_i;

  assign rsp_valid_o           = (r_state == ST_RSP);
  assign rsp_victim_way_o      = r_rsp_way;
  assign busy_o                = !w_empty || (r_state == ST_RSP);

endmodule
